wb2uart_tx: RTL and testbench

WB2UART_TX -- requirements
Module: wb2uart_tx

---
 rtl/wb2uart_tx_pkg.sv | 34 +++
 rtl/wb2uart_tx_if.sv | 12 +
 rtl/wb2uart_tx_fifo_sync.sv | 57 +++++
 rtl/wb2uart_tx.sv | 174 +++++++++++++++++
 tb/tb_wb2uart_tx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb2uart_tx_pkg.sv
// Shared register map, status bit positions and transmitter types for the wb2* peripherals.
package wb2uart_tx_pkg;

  localparam int unsigned DIV_W = 16;

  localparam logic [1:0] ADR_TXDATA = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_DIVLO  = 2'd2;
  localparam logic [1:0] ADR_DIVHI  = 2'd3;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_FULL = 1;
  localparam int unsigned ST_OVF  = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // One bus access as captured on the request cycle.
  typedef struct packed {
    logic [1:0] adr;
    logic       we;
    logic [7:0] dat;
  } wb_req_t;

  // A divisor of zero still gives a one-clock bit.
  function automatic logic [DIV_W-1:0] bit_period(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/wb2uart_tx_if.sv
// Wishbone-lite slave bus of the UART transmitter.
interface wb2uart_tx_if;
  logic [1:0] i_adr;
  logic       i_stb;
  logic       i_we;
  logic [7:0] i_dat;
  logic       o_ack;
  logic [7:0] o_dat;

  modport master (output i_adr, i_stb, i_we, i_dat, input o_ack, o_dat);
  modport slave  (input i_adr, i_stb, i_we, i_dat, output o_ack, o_dat);
endinterface

// File: rtl/wb2uart_tx_fifo_sync.sv
// Synchronous FIFO with wrap-bit pointers; push while full is accepted only alongside a pop.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // Pointer advance and flag lookahead from the next pointer values.
  always_comb begin
    do_pop  = pop_i && !empty_q;
    do_push = push_i && (!full_q || do_pop);
    wptr_d  = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;
    empty_d = (wptr_d == rptr_d);
    full_d  = ((wptr_d ^ rptr_d) == {1'b1, {AW{1'b0}}});
  end

  // Pointer and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/wb2uart_tx.sv
// Wishbone-attached 8N1 UART transmitter with TX FIFO, programmable divisor and idle interrupt.
module wb2uart_tx
  import wb2uart_tx_pkg::*;
#(
  parameter logic [15:0] CLK_DIV_RST = 16'd434,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  wb2uart_tx_if.slave bus,
  output logic        o_tx,
  output logic        o_irq
);

  logic             ack_q, ack_d;
  logic [7:0]       dat_q, dat_d, rd_data;
  wb_req_t          req_q, req_d;
  logic             ovf_q, ovf_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             acc_wr, push_c, ovf_set, ovf_clr;
  logic             fifo_full, fifo_empty, pop_c;
  logic [7:0]       fifo_dout;

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, per_q, per_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic             tx_q, tx_d, irq_q, irq_d;
  logic             bit_end, busy;

  assign bus.o_ack = ack_q;
  assign bus.o_dat = dat_q;
  assign o_tx      = tx_q;
  assign o_irq     = irq_q;
  assign busy      = (state_q != TX_IDLE);
  assign bit_end   = (cnt_q == per_q - DIV_W'(1));

  fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .din_i   (req_q.dat),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bus handshake, read mux and register side effects (applied while ack is high).
  always_comb begin
    ack_d   = bus.i_stb && !ack_q;
    rd_data = 8'h00;
    case (bus.i_adr)
      ADR_STATUS: begin
        rd_data[ST_BUSY] = busy;
        rd_data[ST_FULL] = fifo_full;
        rd_data[ST_OVF]  = ovf_q;
      end
      ADR_DIVLO: rd_data = div_q[7:0];
      ADR_DIVHI: rd_data = div_q[15:8];
      default:   rd_data = 8'h00;
    endcase
    dat_d   = (ack_d && !bus.i_we) ? rd_data : 8'h00;
    req_d   = ack_d ? wb_req_t'{adr: bus.i_adr, we: bus.i_we, dat: bus.i_dat} : req_q;
    acc_wr  = ack_q && req_q.we;
    push_c  = acc_wr && (req_q.adr == ADR_TXDATA);
    ovf_clr = acc_wr && (req_q.adr == ADR_STATUS);
    ovf_set = push_c && fifo_full && !pop_c;
    ovf_d   = ovf_set || (ovf_q && !ovf_clr);
    div_d   = div_q;
    if (acc_wr && (req_q.adr == ADR_DIVLO)) div_d[7:0]  = req_q.dat;
    if (acc_wr && (req_q.adr == ADR_DIVHI)) div_d[15:8] = req_q.dat;
  end

  // Bus-side registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q <= 1'b0;
      dat_q <= 8'h00;
      req_q <= '0;
      ovf_q <= 1'b0;
      div_q <= CLK_DIV_RST;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      req_q <= req_d;
      ovf_q <= ovf_d;
      div_q <= div_d;
    end
  end

  // Transmitter state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= TX_IDLE;
    else       state_q <= state_d;
  end

  // Transmitter next state; stop bit chains straight into the next start when data waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (!fifo_empty) state_d = TX_START;
      TX_START: if (bit_end) state_d = TX_DATA;
      TX_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = TX_STOP;
      TX_STOP:  if (bit_end) state_d = fifo_empty ? TX_IDLE : TX_START;
      default:  state_d = TX_IDLE;
    endcase
  end

  // Transmitter datapath and outputs; bit period is resampled from the divisor at each bit boundary.
  always_comb begin
    pop_c   = 1'b0;
    cnt_d   = cnt_q + DIV_W'(1);
    per_d   = per_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_dout;
          per_d   = bit_period(div_q);
        end
      end
      TX_START: if (bit_end) begin
        cnt_d = '0;
        per_d = bit_period(div_q);
        bit_d = 3'd0;
      end
      TX_DATA: if (bit_end) begin
        cnt_d   = '0;
        per_d   = bit_period(div_q);
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end
      TX_STOP: if (bit_end) begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_dout;
          per_d   = bit_period(div_q);
        end
      end
      default: cnt_d = '0;
    endcase
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    irq_d = fifo_empty && (state_q == TX_IDLE);
  end

  // Transmitter datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      per_q   <= DIV_W'(1);
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_wb2uart_tx.sv
// Bench for wb2uart_tx: bus accesses against a byte queue, serial line decoded by a frame receiver.
module tb_wb2uart_tx;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic tx, irq;

  always #5 clk = ~clk;

  wb2uart_tx_if bus ();

  wb2uart_tx #(.CLK_DIV_RST(16'd434), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus),
    .o_tx  (tx),
    .o_irq (irq)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         starts_q[$];
  int         exp_per = 434;
  int         cyc = 0;
  bit         mon_en = 1'b1;
  bit         in_frame = 1'b0;
  int         mon_k = 0;

  // Count a comparison and report it if it mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Frame receiver: every cycle of a 10-bit 8N1 frame must hold the ideal level, irq must stay low.
  initial begin
    int         b, pos, mon_p, mon_bad;
    logic       lvl;
    logic [7:0] mon_exp, mon_rx;
    mon_p = 1; mon_bad = 0; mon_exp = 8'h00; mon_rx = 8'h00;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        in_frame = 1'b0;
        mon_k    = 0;
      end else if (in_frame) begin
        b   = mon_k / mon_p;
        pos = mon_k % mon_p;
        lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mon_exp[3'(b - 1)];
        if (tx !== lvl) mon_bad++;
        if (irq !== 1'b0) mon_bad++;
        if (b >= 1 && b <= 8 && pos == mon_p / 2) mon_rx[3'(b - 1)] = tx;
        mon_k++;
        if (mon_k == 10 * mon_p) begin
          in_frame = 1'b0;
          check("frame_byte", 32'(mon_rx), 32'(mon_exp));
          check("frame_shape", 32'(mon_bad), 32'd0);
        end
      end else if (tx === 1'b0) begin
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        mon_p   = exp_per;
        mon_rx  = 8'h00;
        mon_bad = (irq !== 1'b0) ? 1 : 0;
        starts_q.push_back(cyc);
        in_frame = 1'b1;
        mon_k    = 1;
      end
    end
  end

  // All bus tasks start and end on a falling edge.
  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    bus.i_adr = a; bus.i_we = 1'b1; bus.i_dat = d; bus.i_stb = 1'b1;
    @(negedge clk);
    check("wr_ack", 32'(bus.o_ack), 32'd1);
    bus.i_stb = 1'b0; bus.i_we = 1'b0;
    @(negedge clk);
    check("wr_ack_pulse", 32'(bus.o_ack), 32'd0);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [7:0] d);
    bus.i_adr = a; bus.i_we = 1'b0; bus.i_stb = 1'b1;
    @(negedge clk);
    check("rd_ack", 32'(bus.o_ack), 32'd1);
    d = bus.o_dat;
    bus.i_stb = 1'b0;
    @(negedge clk);
    check("rd_dat_idle", 32'(bus.o_dat), 32'd0);
  endtask

  task automatic read_expect(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    wb_read(a, d);
    check(tag, 32'(d), 32'(exp));
  endtask

  task automatic set_div(input int v);
    logic [15:0] d16;
    d16 = 16'(v);
    wb_write(2'd2, d16[7:0]);
    wb_write(2'd3, d16[15:8]);
    exp_per = (v == 0) ? 1 : v;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_tx);
    if (expect_tx) exp_q.push_back(b);
    wb_write(2'd0, b);
  endtask

  // Wait until every expected byte has gone out and the interrupt reports idle.
  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      #1;
      done = (exp_q.size() == 0) && !in_frame && (irq === 1'b1);
    end
    check("drain", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int          n0, c, n, lows;
    bit          reached;
    logic [7:0]  b;
    rst = 1'b1;
    bus.i_adr = 2'd0; bus.i_stb = 1'b0; bus.i_we = 1'b0; bus.i_dat = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd1);
    check("rst_ack", 32'(bus.o_ack), 32'd0);
    check("rst_dat", 32'(bus.o_dat), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset register values.
    read_expect("status_rst", 2'd1, 8'h00);
    read_expect("divlo_rst", 2'd2, 8'hB2);
    read_expect("divhi_rst", 2'd3, 8'h01);
    read_expect("txdata_rd", 2'd0, 8'h00);

    // Single frame at div 4, popped the cycle after the push lands.
    set_div(4);
    n0 = starts_q.size();
    push(8'hA5, 1'b1);
    c = cyc;
    wait_idle(200);
    check("a5_frames", 32'(starts_q.size() - n0), 32'd1);
    if (starts_q.size() > n0) check("a5_start_lat", 32'(starts_q[n0] - c), 32'd1);
    check("a5_tx_idle", 32'(tx), 32'd1);

    // Back-to-back frames at div 2.
    set_div(2);
    n0 = starts_q.size();
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    wait_idle(200);
    check("b2b_frames", 32'(starts_q.size() - n0), 32'd2);
    if (starts_q.size() >= n0 + 2) check("b2b_gap", 32'(starts_q[n0+1] - starts_q[n0]), 32'd20);

    // Strobe held for six cycles: three acks, three pushes.
    n0 = starts_q.size();
    repeat (3) exp_q.push_back(8'h3C);
    n = 0;
    bus.i_adr = 2'd0; bus.i_we = 1'b1; bus.i_dat = 8'h3C; bus.i_stb = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n += (bus.o_ack === 1'b1) ? 1 : 0;
    end
    bus.i_stb = 1'b0; bus.i_we = 1'b0;
    @(negedge clk);
    check("held_acks", 32'(n), 32'd3);
    wait_idle(300);
    check("held_frames", 32'(starts_q.size() - n0), 32'd3);

    // Overflow: shifter plus FIFO absorb DEPTH+1 bytes, the last one is dropped.
    set_div(200);
    n0 = starts_q.size();
    c  = 0;
    for (int k = 0; k < int'(DEPTH) + 2; k++) begin
      b = 8'($urandom_range(0, 255));
      push(b, k < int'(DEPTH) + 1);
      if (k == 0) c = cyc;
    end
    read_expect("status_ovf", 2'd1, 8'h07);
    wb_write(2'd1, 8'h5A);
    read_expect("status_ovf_clr", 2'd1, 8'h03);
    wait_idle((int'(DEPTH) + 1) * 2000 + 200);
    check("ovf_frames", 32'(starts_q.size() - n0), 32'(DEPTH + 1));
    if (starts_q.size() > n0) check("ovf_first_lat", 32'(starts_q[n0] - c), 32'd1);
    read_expect("status_done", 2'd1, 8'h00);

    // Random divisors (including 0) and burst lengths that never overflow.
    for (int r = 0; r < 12; r++) begin
      int d;
      d = $urandom_range(0, 5);
      set_div(d);
      n = $urandom_range(1, DEPTH + 1);
      n0 = starts_q.size();
      for (int k = 0; k < n; k++) push(8'($urandom_range(0, 255)), 1'b1);
      wait_idle(n * 10 * exp_per + 100);
      check("rand_frames", 32'(starts_q.size() - n0), 32'(n));
    end

    // Reset during DATA bit 3 aborts the frame and drops queued bytes.
    set_div(4);
    push(8'hF0, 1'b1);
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      #1;
      reached = in_frame && (mon_k == 17);
    end
    check("reach_bit3", 32'(reached), 32'd1);
    mon_en = 1'b0;
    check("pre_rst_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_irq", 32'(irq), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_per = 434;
    @(negedge clk);
    read_expect("status_after_rst", 2'd1, 8'h00);
    read_expect("divlo_after_rst", 2'd2, 8'hB2);
    read_expect("divhi_after_rst", 2'd3, 8'h01);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      lows += (tx !== 1'b1) ? 1 : 0;
    end
    check("no_frame_after_rst", 32'(lows), 32'd0);
    check("irq_after_rst", 32'(irq), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
